// File: rtl/assoc_cache_ctrl.sv
// Fully-associative write-through cache controller with true-LRU age counters,
// a registered request/response FSM, flush and saturating hit/miss statistics.
module assoc_cache_ctrl #(
  parameter int D_WIDTH = 8,
  parameter int A_WIDTH = 8,
  parameter int ENTRIES = 4,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int STAT_W  = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [A_WIDTH-1:0] cpu_addr,
  input  logic [D_WIDTH-1:0] cpu_wdata,
  output logic               cpu_ready,
  output logic               cpu_done,
  output logic [D_WIDTH-1:0] cpu_rdata,
  output logic               cpu_hit,
  input  logic               flush,
  output logic               mem_req,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               mem_ack,
  output logic [STAT_W-1:0]  hit_count,
  output logic [STAT_W-1:0]  miss_count,
  output logic [2:0]         dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOOKUP = 3'd1,
    S_MEM_RD = 3'd2,
    S_MEM_WR = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  // Handshake: a request is accepted on a rising edge where cpu_ready=1 and
  // cpu_req=1; it completes with a single-cycle cpu_done. Toward memory,
  // mem_req is held until the edge that samples mem_ack=1.
  state_t state, state_nxt;

  logic [A_WIDTH-1:0] tag_q  [ENTRIES];
  logic [D_WIDTH-1:0] data_q [ENTRIES];
  logic [IDX_W-1:0]   age_q  [ENTRIES];
  logic [ENTRIES-1:0] valid_q;

  logic               req_we;
  logic [A_WIDTH-1:0] req_addr;
  logic [D_WIDTH-1:0] req_wdata;

  logic               hit;
  logic [IDX_W-1:0]   hit_idx;
  logic [IDX_W-1:0]   vic_idx;
  logic               do_touch;
  logic [IDX_W-1:0]   touch_idx;
  logic               do_flush;
  logic               do_fill;

  assign cpu_ready = (state == S_IDLE);
  assign dbg_state = state;
  assign do_flush  = (state == S_IDLE) && flush;
  assign do_fill   = (state == S_MEM_RD) && mem_ack;

  // Descending scans so the lowest matching index is the one left standing.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    vic_idx = '0;
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && tag_q[i] == req_addr) begin
        hit     = 1'b1;
        hit_idx = IDX_W'(i);
      end
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (age_q[i] == '0) vic_idx = IDX_W'(i);
    end
    for (int i = ENTRIES - 1; i >= 0; i--) begin
      if (!valid_q[i]) vic_idx = IDX_W'(i);
    end
  end

  always_comb begin
    do_touch  = 1'b0;
    touch_idx = '0;
    if (state == S_LOOKUP && hit) begin
      do_touch  = 1'b1;
      touch_idx = hit_idx;
    end else if (do_fill) begin
      do_touch  = 1'b1;
      touch_idx = vic_idx;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:   if (!flush && cpu_req) state_nxt = S_LOOKUP;
      S_LOOKUP: begin
        if (req_we)   state_nxt = S_MEM_WR;
        else if (hit) state_nxt = S_DONE;
        else          state_nxt = S_MEM_RD;
      end
      S_MEM_RD: if (mem_ack) state_nxt = S_DONE;
      S_MEM_WR: if (mem_ack) state_nxt = S_DONE;
      S_DONE:   state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Tag/data arrays are qualified by valid_q, so they carry no reset.
  always_ff @(posedge clk) begin
    if (state == S_LOOKUP && hit && req_we) data_q[hit_idx] <= req_wdata;
    if (do_fill) begin
      tag_q[vic_idx]  <= req_addr;
      data_q[vic_idx] <= mem_rdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
      req_we     <= 1'b0;
      req_addr   <= '0;
      req_wdata  <= '0;
      cpu_done   <= 1'b0;
      cpu_hit    <= 1'b0;
      cpu_rdata  <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      cpu_done <= (state_nxt == S_DONE);
      if (do_flush) begin
        valid_q <= '0;
        for (int i = 0; i < ENTRIES; i++) age_q[i] <= IDX_W'(i);
      end else if (do_touch) begin
        for (int i = 0; i < ENTRIES; i++) begin
          if (IDX_W'(i) == touch_idx)        age_q[i] <= IDX_W'(ENTRIES - 1);
          else if (age_q[i] > age_q[touch_idx]) age_q[i] <= age_q[i] - 1'b1;
        end
      end
      if (state == S_IDLE && !flush && cpu_req) begin
        req_we    <= cpu_we;
        req_addr  <= cpu_addr;
        req_wdata <= cpu_wdata;
      end
      if (state == S_LOOKUP) begin
        cpu_hit <= hit;
        if (hit) begin
          if (!req_we) cpu_rdata <= data_q[hit_idx];
          if (hit_count != '1) hit_count <= hit_count + 1'b1;
        end else if (miss_count != '1) begin
          miss_count <= miss_count + 1'b1;
        end
        if (req_we) begin
          mem_req   <= 1'b1;
          mem_we    <= 1'b1;
          mem_addr  <= req_addr;
          mem_wdata <= req_wdata;
        end else if (!hit) begin
          mem_req  <= 1'b1;
          mem_we   <= 1'b0;
          mem_addr <= req_addr;
        end
      end
      if (do_fill) begin
        valid_q[vic_idx] <= 1'b1;
        cpu_rdata        <= mem_rdata;
        cpu_hit          <= 1'b0;
      end
      if ((state == S_MEM_RD || state == S_MEM_WR) && mem_ack) mem_req <= 1'b0;
    end
  end

endmodule
